// File: rtl/pw_pkg.sv
// Shared definitions for the password verification slice: word width, FSM state
// encoding and the layout of an attempt-log word.
package pw_pkg;

  localparam int unsigned PW_WIDTH = 16;
  localparam logic [PW_WIDTH-1:0] PW_UNPROGRAMMED = 16'h0000;

  // Attempt-log word: {match, fail_cnt[2:0], user_id[11:0]}
  localparam int unsigned LOG_MATCH_BIT = 15;
  localparam int unsigned LOG_FAIL_LSB  = 12;
  localparam int unsigned LOG_FAIL_W    = 3;
  localparam int unsigned LOG_UID_W     = 12;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCmp,
    StLog,
    StDone,
    StLock
  } pw_state_e;

  function automatic logic [PW_WIDTH-1:0] pack_log_word(input logic                  m,
                                                        input logic [LOG_FAIL_W-1:0] fc,
                                                        input logic [LOG_UID_W-1:0]  uid);
    logic [PW_WIDTH-1:0] w;
    w = '0;
    w[LOG_MATCH_BIT] = m;
    w[LOG_FAIL_LSB +: LOG_FAIL_W] = fc;
    w[LOG_UID_W-1:0] = uid;
    return w;
  endfunction

endpackage

// File: rtl/password_verify_ctrl_if.sv
// Start/done handshake between the keypad front end (master) and the verifier (slave).
interface password_verify_ctrl_if;
    import pw_pkg::*;

    logic                start;
    logic [PW_WIDTH-1:0] user_id;
    logic [PW_WIDTH-1:0] entry;
    logic                busy;
    logic                done;
    logic                match;
    logic                locked;
    logic [2:0]          fail_cnt;

    modport master (
        output start, user_id, entry,
        input  busy, done, match, locked, fail_cnt
    );

    modport slave (
        input  start, user_id, entry,
        output busy, done, match, locked, fail_cnt
    );

endinterface

// File: rtl/pw_lockout_timer.sv
// Loadable down-counter; expire pulses in the last cycle of a loaded count.
module pw_lockout_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/password_verify_ctrl.sv
// Checks an entered password against the ROM, counts failures and enforces lockout.
// Define PW_ATTEMPT_LOG_EN to log every attempt into the password RAM ring.
module password_verify_ctrl
    import pw_pkg::*;
#(
    parameter int unsigned   ROM_LAT     = 1,
    parameter int unsigned   MAX_FAILS   = 3,
    parameter int unsigned   LOCK_CYCLES = 1000,
    parameter logic [15:0]   LOG_BASE    = 16'h8000,
    parameter int unsigned   LOG_DEPTH   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    password_verify_ctrl_if.slave ctl,
    output logic [PW_WIDTH-1:0]   rom_addr,
    input  logic [PW_WIDTH-1:0]   rom_data,
    output logic [PW_WIDTH-1:0]   ram_addr,
    output logic [PW_WIDTH-1:0]   ram_wdata,
    output logic                  ram_wren
);

    localparam int unsigned WaitW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
    localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);
    localparam logic [2:0]  MaxF  = 3'(MAX_FAILS);

    if (MAX_FAILS < 1 || MAX_FAILS > 7) begin : g_chk_max_fails
        $error("MAX_FAILS must be in 1..7");
    end
    if (LOCK_CYCLES < 1) begin : g_chk_lock_cycles
        $error("LOCK_CYCLES must be at least 1");
    end
    if (LOG_DEPTH == 0 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_chk_log_depth
        $error("LOG_DEPTH must be a power of two");
    end
    if (32'(LOG_BASE) + LOG_DEPTH > 32'h0001_0000) begin : g_chk_log_span
        $error("attempt log ring runs past the top of RAM");
    end

    pw_state_e           state_q;
    logic [WaitW-1:0]    wait_cnt_q;
    logic [PW_WIDTH-1:0] user_id_q;
    logic [PW_WIDTH-1:0] entry_q;
    logic                busy_q;
    logic                done_q;
    logic                match_q;
    logic                locked_q;
    logic [2:0]          fail_cnt_q;

    logic                cmp_match;
    logic [2:0]          fail_next;
    logic                lock_load;
    logic                lock_expire;

    // An all-zero ROM word is an unprogrammed slot and can never match.
    always_comb begin
        cmp_match = (rom_data == entry_q) && (rom_data != PW_UNPROGRAMMED);
        fail_next = fail_cnt_q;
        if (cmp_match) begin
            fail_next = '0;
        end else if (fail_cnt_q != MaxF) begin
            fail_next = fail_cnt_q + 3'd1;
        end
    end

    assign lock_load = (state_q == StDone) && (fail_cnt_q == MaxF);

    pw_lockout_timer #(
        .WIDTH (LockW)
    ) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load),
        .load_val (LockW'(LOCK_CYCLES)),
        .expire   (lock_expire)
    );

`ifdef PW_ATTEMPT_LOG_EN
    localparam int unsigned LogPtrW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    logic [LogPtrW-1:0]  log_ptr_q;
    logic [PW_WIDTH-1:0] ram_addr_q;
    logic [PW_WIDTH-1:0] ram_wdata_q;
    logic                ram_wren_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            user_id_q  <= '0;
            entry_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
`ifdef PW_ATTEMPT_LOG_EN
            log_ptr_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef PW_ATTEMPT_LOG_EN
            ram_wren_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (ctl.start && !locked_q) begin
                        user_id_q  <= ctl.user_id;
                        entry_q    <= ctl.entry;
                        busy_q     <= 1'b1;
                        match_q    <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == WaitW'(ROM_LAT)) begin
                        state_q <= StCmp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StCmp: begin
                    match_q    <= cmp_match;
                    fail_cnt_q <= fail_next;
`ifdef PW_ATTEMPT_LOG_EN
                    ram_wren_q  <= 1'b1;
                    ram_addr_q  <= LOG_BASE + PW_WIDTH'(log_ptr_q);
                    ram_wdata_q <= pack_log_word(cmp_match, fail_next,
                                                 user_id_q[LOG_UID_W-1:0]);
                    log_ptr_q   <= (log_ptr_q == LogPtrW'(LOG_DEPTH - 1)) ? '0
                                                                          : log_ptr_q + 1'b1;
                    state_q     <= StLog;
`else
                    done_q  <= 1'b1;
                    state_q <= StDone;
`endif
                end
                StLog: begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    busy_q <= 1'b0;
                    if (fail_cnt_q == MaxF) begin
                        locked_q <= 1'b1;
                        state_q  <= StLock;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StLock: begin
                    if (lock_expire) begin
                        locked_q   <= 1'b0;
                        fail_cnt_q <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctl.busy     = busy_q;
    assign ctl.done     = done_q;
    assign ctl.match    = match_q;
    assign ctl.locked   = locked_q;
    assign ctl.fail_cnt = fail_cnt_q;
    assign rom_addr     = user_id_q;

`ifdef PW_ATTEMPT_LOG_EN
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wren  = ram_wren_q;
`else
    assign ram_addr  = '0;
    assign ram_wdata = '0;
    assign ram_wren  = 1'b0;
`endif

endmodule

// File: tb/tb_password_verify_ctrl.sv
// Self-checking bench for password_verify_ctrl: vector table, hand sequences for lockout,
// held start and mid-operation reset, then random attempts against a reference model.
module tb_password_verify_ctrl;

    localparam int MAX_FAILS   = 3;
    localparam int LOCK_CYCLES = 1000;
    localparam int LOG_DEPTH   = 4;
`ifdef PW_ATTEMPT_LOG_EN
    localparam bit LOG_ON = 1'b1;
`else
    localparam bit LOG_ON = 1'b0;
`endif
    // ROM_LAT=1: accept edge to done cycle is ROM_LAT+2, one more with logging
    localparam int EXP_LAT = LOG_ON ? 4 : 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    password_verify_ctrl_if pif ();
    logic [15:0] rom_addr, rom_data, ram_addr, ram_wdata;
    logic        ram_wren;

    password_verify_ctrl #(
        .ROM_LAT     (1),
        .MAX_FAILS   (MAX_FAILS),
        .LOCK_CYCLES (LOCK_CYCLES),
        .LOG_BASE    (16'h8000),
        .LOG_DEPTH   (LOG_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctl       (pif.slave),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren)
    );

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a == 16'h1476) return 16'hBEEF;
        if (a == 16'h0001) return 16'h0000;
        return ~a;
    endfunction

    // One-cycle synchronous ROM
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    logic [31:0] wr_q[$];
    always @(negedge clk) if (ram_wren) wr_q.push_back({ram_addr, ram_wdata});

    int n_checks = 0;
    int n_fail   = 0;
    int m_fail   = 0;
    int m_ptr    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string tag, input bit exp_m, input logic [2:0] exp_f,
                             input logic [15:0] uid);
        logic [15:0] exp_a, exp_w;
        if (LOG_ON) begin
            exp_a = 16'(32'h8000 + m_ptr);
            exp_w = {exp_m, exp_f, uid[11:0]};
            check({tag, " log writes"}, wr_q.size(), 1);
            if (wr_q.size() >= 1) check({tag, " log entry"}, wr_q[0], {exp_a, exp_w});
            m_ptr = (m_ptr + 1) % LOG_DEPTH;
        end else begin
            check({tag, " no ram write"}, wr_q.size(), 0);
            check({tag, " ram tied"}, {ram_addr, ram_wdata}, 32'h0);
        end
    endtask

    task automatic lock_phase(input string tag);
        int  n_locked;
        bit  saw_done, saw_busy;
        n_locked = 1;
        saw_done = 0;
        saw_busy = 0;
        wr_q.delete();
        for (int k = 0; k < 2 * LOCK_CYCLES; k++) begin
            @(negedge clk);
            pif.start   = (k == 10);
            pif.user_id = 16'h1476;
            pif.entry   = 16'hBEEF;
            @(posedge clk); #1;
            if (pif.done) saw_done = 1;
            if (pif.busy) saw_busy = 1;
            if (!pif.locked) break;
            n_locked++;
        end
        pif.start = 1'b0;
        check({tag, " lock length"}, n_locked, LOCK_CYCLES);
        check({tag, " no done in lock"}, 32'(saw_done), 0);
        check({tag, " no busy in lock"}, 32'(saw_busy), 0);
        check({tag, " fail_cnt after lock"}, pif.fail_cnt, 0);
        check({tag, " no ram write in lock"}, wr_q.size(), 0);
        m_fail = 0;
    endtask

    task automatic run_attempt(input string tag, input logic [15:0] uid, input logic [15:0] ent,
                               input bit exp_m, input logic [2:0] exp_f);
        bit got, busy_bad;
        int lat;
        wr_q.delete();
        @(negedge clk);
        pif.start   = 1'b1;
        pif.user_id = uid;
        pif.entry   = ent;
        @(posedge clk); #1;
        pif.start   = 1'b0;
        pif.user_id = 16'($urandom);
        pif.entry   = 16'($urandom);
        got = 0;
        busy_bad = 0;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            if (!pif.busy) busy_bad = 1;
            if (pif.done) begin
                got = 1;
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " done seen"}, 32'(got), 1);
        check({tag, " latency"}, lat, EXP_LAT);
        check({tag, " busy held"}, 32'(busy_bad), 0);
        check({tag, " rom_addr"}, rom_addr, uid);
        check({tag, " match"}, pif.match, exp_m);
        check({tag, " fail_cnt"}, pif.fail_cnt, exp_f);
        @(posedge clk); #1;
        check({tag, " done one cycle"}, {pif.done, pif.busy}, 0);
        check({tag, " match held"}, pif.match, exp_m);
        check({tag, " locked"}, pif.locked, 32'(exp_f == 3'(MAX_FAILS)));
        check_log(tag, exp_m, exp_f, uid);
        m_fail = exp_f;
        if (exp_f == 3'(MAX_FAILS)) lock_phase(tag);
    endtask

    typedef struct {
        logic [15:0] uid;
        logic [15:0] ent;
        bit          exp_m;
        logic [2:0]  exp_f;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [15:0] uid, ent, w;
        bit          em;
        logic [2:0]  ef;
        int          t0, gap;
        bit          got;

        vecs.push_back('{16'h1476, 16'hBEEF, 1'b1, 3'd0});
        vecs.push_back('{16'h0001, 16'h0000, 1'b0, 3'd1});
        vecs.push_back('{16'h1476, 16'hAAAA, 1'b0, 3'd2});
        vecs.push_back('{16'h1476, 16'hBEEF, 1'b1, 3'd0});
        vecs.push_back('{16'h1476, 16'h1234, 1'b0, 3'd1});
        vecs.push_back('{16'h2222, 16'hDDDD, 1'b1, 3'd0});
        vecs.push_back('{16'h1476, 16'hAAAA, 1'b0, 3'd1});
        vecs.push_back('{16'h1476, 16'hAAAA, 1'b0, 3'd2});
        vecs.push_back('{16'h1476, 16'hAAAA, 1'b0, 3'd3});
        vecs.push_back('{16'h1476, 16'hBEEF, 1'b1, 3'd0});

        pif.start   = 1'b0;
        pif.user_id = '0;
        pif.entry   = '0;
        #3;
        check("reset outputs", {pif.busy, pif.done, pif.match, pif.locked, pif.fail_cnt},
              32'h0);
        check("reset rom_addr", rom_addr, 0);
        check("reset ram", {ram_addr, ram_wdata}, 32'h0);
        check("reset ram_wren", ram_wren, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        @(posedge clk); #1;
        check("no write after reset", wr_q.size(), 0);

        foreach (vecs[i]) run_attempt($sformatf("vec%0d", i), vecs[i].uid, vecs[i].ent,
                                      vecs[i].exp_m, vecs[i].exp_f);

        // start held high through done re-arms in the following IDLE cycle
        wr_q.delete();
        @(negedge clk);
        pif.start   = 1'b1;
        pif.user_id = 16'h1476;
        pif.entry   = 16'hBEEF;
        got = 0;
        t0  = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (pif.done) begin
                got = 1;
                t0  = k;
            end
        end
        check("held start first done", 32'(got), 1);
        check("held start first match", pif.match, 1);
        got = 0;
        gap = -1;
        for (int k = 1; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (pif.done) begin
                got = 1;
                gap = k;
            end
        end
        @(negedge clk);
        pif.start = 1'b0;
        check("held start second done gap", gap, EXP_LAT + 2);
        check("held start second match", pif.match, 1);
        check("held start writes", wr_q.size(), LOG_ON ? 2 : 0);
        if (LOG_ON) m_ptr = (m_ptr + 2) % LOG_DEPTH;
        repeat (4) @(posedge clk);
        #1;

        // reset during WAIT aborts the check
        run_attempt("pre-reset fail", 16'h1476, 16'h5555, 1'b0, 3'd1);
        @(negedge clk);
        pif.start   = 1'b1;
        pif.user_id = 16'h1476;
        pif.entry   = 16'hBEEF;
        @(posedge clk); #1;
        pif.start = 1'b0;
        wr_q.delete();
        rst = 1'b1;
        #1;
        check("midop reset outputs", {pif.busy, pif.done, pif.match, pif.locked, pif.fail_cnt},
              32'h0);
        check("midop reset rom_addr", rom_addr, 0);
        check("midop reset ram", {ram_wren, ram_addr, ram_wdata}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (pif.done || pif.busy) got = 1;
        end
        check("midop reset no done", 32'(got), 0);
        check("midop reset no write", wr_q.size(), 0);
        m_fail = 0;
        m_ptr  = 0;
        run_attempt("post-reset", 16'h1476, 16'hBEEF, 1'b1, 3'd0);

        // random attempts against the reference model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       uid = 16'h1476;
                1:       uid = 16'h0001;
                default: uid = 16'($urandom);
            endcase
            w   = rom_word(uid);
            ent = ($urandom_range(0, 1) == 1) ? w : 16'($urandom);
            em  = (ent == w) && (w != 16'h0000);
            ef  = em ? 3'd0 : 3'((m_fail >= MAX_FAILS) ? MAX_FAILS : m_fail + 1);
            run_attempt($sformatf("rand%0d", i), uid, ent, em, ef);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
